// File: rtl/apb_cordic_jobq.sv
// -----------------------------------------------------------------------------
// apb_cordic_jobq
//
// APB slave front-end for a CORDIC core. Software stages two operands (OPA and
// OPB) and pushes {cmd, OPA, OPB} jobs into a job FIFO. A small sequencer hands
// the jobs to the core one at a time and stores each {RES0, RES1} pair in a
// result FIFO. INT is a level interrupt. It fires when the result count reaches
// a threshold, or when one of the sticky error bits is set.
//
// Register map (byte addresses, word aligned):
//   0x00 CTRL  RW      [0] EN, [1] FLUSH (write-1 pulse, reads 0), [2] IRQEN,
//                      [15:8] THRESH
//   0x04 STAT  RO/W1C  [7:0] job count, [15:8] result count, [16] BUSY,
//                      [17] OVF, [18] UDF, [19] TMO (bits 17-19 write-1-clear)
//   0x08 OPA   RW      staging operand A
//   0x0C OPB   RW      staging operand B
//   0x10 PUSH  WO      [2:0] cmd, enqueues {cmd, OPA, OPB}
//   0x14 RES0  RO      head RES0, does not pop
//   0x18 RES1  RO      head RES1, pops the head entry
//   Any other address reads 0, ignores writes and answers with PSLVERR.
//
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   PSEL .. PWDATA      APB request (zero wait states, PREADY tied high)
//   PRDATA, PSLVERR     APB response, valid in the access phase
//   INT                 registered level interrupt
//   core_start/cmd/a/b  one-cycle issue pulse with the head job
//   core_done/res0/res1 one-cycle completion pulse with the results
// -----------------------------------------------------------------------------
module apb_cordic_jobq #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 6,
   parameter int JOB_DEPTH = 4,
   parameter int RES_DEPTH = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic              PWRITE,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              INT,
   output logic              core_start,
   output logic [2:0]        core_cmd,
   output logic [DATA_W-1:0] core_a,
   output logic [DATA_W-1:0] core_b,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_res0,
   input  logic [DATA_W-1:0] core_res1
);

   localparam int JPW = $clog2(JOB_DEPTH);
   localparam int JCW = JPW + 1;
   localparam int RPW = $clog2(RES_DEPTH);
   localparam int RCW = RPW + 1;
   localparam int TW  = $clog2(TIMEOUT + 1);

   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(32'h00);
   localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(32'h04);
   localparam logic [ADDR_W-1:0] A_OPA  = ADDR_W'(32'h08);
   localparam logic [ADDR_W-1:0] A_OPB  = ADDR_W'(32'h0C);
   localparam logic [ADDR_W-1:0] A_PUSH = ADDR_W'(32'h10);
   localparam logic [ADDR_W-1:0] A_RES0 = ADDR_W'(32'h14);
   localparam logic [ADDR_W-1:0] A_RES1 = ADDR_W'(32'h18);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   typedef struct packed {
      logic [2:0]        cmd;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } job_t;

   typedef struct packed {
      logic [DATA_W-1:0] r0;
      logic [DATA_W-1:0] r1;
   } res_t;

   // ---------------------------------------------------------------- storage
   logic              en, irqen;
   logic [7:0]        thresh;
   logic              ovf, udf, tmo;
   logic [DATA_W-1:0] opa, opb;
   logic              irq;

   job_t              job_mem [JOB_DEPTH];
   logic [JPW-1:0]    job_wr, job_rd;
   logic [JCW-1:0]    job_count;

   res_t              res_mem [RES_DEPTH];
   logic [RPW-1:0]    res_wr, res_rd;
   logic [RCW-1:0]    res_count;

   state_t            state, state_next;
   logic [TW-1:0]     timer;
   logic              busy;

   // ---------------------------------------------------------------- APB decode
   logic access, wr, rd, addr_ok;
   logic ctrl_wr, stat_wr, opa_wr, opb_wr;
   logic flush, push_req, push_ok, push_rej;
   logic job_full, res_empty, res_udf, res_pop;
   logic job_pop, res_push, tmo_set;

   assign access   = PSEL & PENABLE;
   assign wr       = access & PWRITE;
   assign rd       = access & ~PWRITE;

   assign addr_ok  = (PADDR == A_CTRL) | (PADDR == A_STAT) | (PADDR == A_OPA)  |
                     (PADDR == A_OPB)  | (PADDR == A_PUSH) | (PADDR == A_RES0) |
                     (PADDR == A_RES1);

   assign ctrl_wr  = wr & (PADDR == A_CTRL);
   assign stat_wr  = wr & (PADDR == A_STAT);
   assign opa_wr   = wr & (PADDR == A_OPA);
   assign opb_wr   = wr & (PADDR == A_OPB);
   assign flush    = ctrl_wr & PWDATA[1];

   // Fullness is judged on the count before this edge, so a push into a full
   // queue is refused even if the sequencer frees a slot on the same edge.
   assign job_full = (job_count == JCW'(JOB_DEPTH));
   assign push_req = wr & (PADDR == A_PUSH);
   assign push_ok  = push_req & ~job_full;
   assign push_rej = push_req & job_full;

   assign res_empty = (res_count == '0);
   assign res_udf   = rd & ((PADDR == A_RES0) | (PADDR == A_RES1)) & res_empty;
   assign res_pop   = rd & (PADDR == A_RES1) & ~res_empty;

   // Flush abandons the in-flight job: neither its pop nor its result counts.
   assign job_pop  = (state == S_ISSUE) & ~flush;
   assign res_push = (state == S_WAIT) & core_done & ~flush;
   assign tmo_set  = (state == S_WAIT) & ~core_done & (timer == TW'(TIMEOUT)) & ~flush;

   assign PREADY  = 1'b1;
   assign PSLVERR = access & (~addr_ok | push_rej | res_udf);
   assign INT     = irq;

   // ---------------------------------------------------------------- read mux
   logic [31:0] ctrl_word, stat_word;

   assign ctrl_word = {16'd0, thresh, 5'd0, irqen, 1'b0, en};
   assign stat_word = {12'd0, tmo, udf, ovf, busy, 8'(res_count), 8'(job_count)};

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      PRDATA = '0;
      if (rd) begin
         case (PADDR)
            A_CTRL:  PRDATA = DATA_W'(ctrl_word);
            A_STAT:  PRDATA = DATA_W'(stat_word);
            A_OPA:   PRDATA = opa;
            A_OPB:   PRDATA = opb;
            A_RES0:  PRDATA = res_empty ? '0 : res_mem[res_rd].r0;
            A_RES1:  PRDATA = res_empty ? '0 : res_mem[res_rd].r1;
            default: PRDATA = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------- registers
   // NOTE: reset is synchronous (PRESET sampled on the clock edge); sequential
   // state uses non-blocking assignments so every register samples pre-edge
   // values regardless of process order.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         en     <= 1'b0;
         irqen  <= 1'b0;
         thresh <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
         tmo    <= 1'b0;
         opa    <= '0;
         opb    <= '0;
         irq    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            en     <= PWDATA[0];
            irqen  <= PWDATA[2];
            thresh <= PWDATA[15:8];
         end
         if (opa_wr) opa <= PWDATA;
         if (opb_wr) opb <= PWDATA;
         // A new error event on the same edge as its W1C wins.
         ovf <= push_rej | (ovf & ~(stat_wr & PWDATA[17]));
         udf <= res_udf  | (udf & ~(stat_wr & PWDATA[18]));
         tmo <= tmo_set  | (tmo & ~(stat_wr & PWDATA[19]));
         irq <= irqen & (((thresh != 8'd0) & (8'(res_count) >= thresh)) | ovf | udf | tmo);
      end
   end

   // ---------------------------------------------------------------- FIFO state
   always_ff @(posedge PCLK) begin
      if (PRESET || flush) begin
         job_wr    <= '0;
         job_rd    <= '0;
         job_count <= '0;
         res_wr    <= '0;
         res_rd    <= '0;
         res_count <= '0;
      end else begin
         if (push_ok)  job_wr <= job_wr + JPW'(1);
         if (job_pop)  job_rd <= job_rd + JPW'(1);
         if (res_push) res_wr <= res_wr + RPW'(1);
         if (res_pop)  res_rd <= res_rd + RPW'(1);
         // Push and pop on the same edge cancel; neither can exceed depth.
         job_count <= job_count + JCW'(push_ok) - JCW'(job_pop);
         res_count <= res_count + RCW'(res_push) - RCW'(res_pop);
      end
   end

   // NOTE: FIFO storage has no reset; an entry is only visible once its
   // pointer/count says it was written, so clearing the counters is enough.
   always_ff @(posedge PCLK) begin
      if (push_ok)  job_mem[job_wr] <= '{cmd: PWDATA[2:0], a: opa, b: opb};
      if (res_push) res_mem[res_wr] <= '{r0: core_res0, r1: core_res1};
   end

   // ---------------------------------------------------------------- sequencer
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= S_IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         // Timer counts WAIT cycles; it restarts at 0 on every WAIT entry.
         timer <= ((state == S_WAIT) && (state_next == S_WAIT)) ? timer + TW'(1) : '0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            // Only issue when the result is guaranteed a slot on completion.
            if (en && (job_count != '0) && (res_count < RCW'(RES_DEPTH)))
               state_next = S_ISSUE;
         end
         S_ISSUE: state_next = S_WAIT;
         S_WAIT: begin
            if (core_done || (timer == TW'(TIMEOUT)))
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (flush) state_next = S_IDLE;
   end

   always_comb begin
      core_start = 1'b0;
      core_cmd   = '0;
      core_a     = '0;
      core_b     = '0;
      busy       = (state != S_IDLE);
      if (state == S_ISSUE) begin
         core_start = 1'b1;
         core_cmd   = job_mem[job_rd].cmd;
         core_a     = job_mem[job_rd].a;
         core_b     = job_mem[job_rd].b;
      end
   end

endmodule

// File: tb/tb_apb_cordic_jobq.sv
// -----------------------------------------------------------------------------
// tb_apb_cordic_jobq
//
// Self-checking bench for apb_cordic_jobq. A table of register accesses covers
// reset values, the map and the error responses. Hand-written sequences then
// cover queueing, overflow, interrupt latency, the core timeout, flush and
// reset in mid-job. A behavioural core model answers core_start. It returns
// res0 = a + 0x1000 and res1 = ~b after done_delay cycles. It can instead
// return fixed values, never answer (done_delay = 0), or fire one manual late
// done pulse.
// -----------------------------------------------------------------------------
module tb_apb_cordic_jobq;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 6;
   localparam int JOB_DEPTH = 4;
   localparam int RES_DEPTH = 4;
   localparam int TIMEOUT   = 255;

   localparam logic [5:0] A_CTRL = 6'h00, A_STAT = 6'h04, A_OPA  = 6'h08,
                          A_OPB  = 6'h0C, A_PUSH = 6'h10, A_RES0 = 6'h14,
                          A_RES1 = 6'h18;

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b1;
   logic              PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [ADDR_W-1:0] PADDR = '0;
   logic [DATA_W-1:0] PWDATA = '0;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY, PSLVERR, INT;
   logic              core_start;
   logic [2:0]        core_cmd;
   logic [DATA_W-1:0] core_a, core_b;
   logic              core_done = 1'b0;
   logic [DATA_W-1:0] core_res0 = '0, core_res1 = '0;

   apb_cordic_jobq #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .JOB_DEPTH(JOB_DEPTH),
      .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .INT(INT),
      .core_start(core_start), .core_cmd(core_cmd), .core_a(core_a),
      .core_b(core_b), .core_done(core_done), .core_res0(core_res0),
      .core_res1(core_res1)
   );

   always #5 PCLK = ~PCLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge PCLK) cyc <= cyc + 1;

   // ------------------------------------------------------------ core model
   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
   } start_t;

   start_t      start_log[$];
   int          done_delay  = 0;
   logic        fixed_en    = 1'b0;
   logic [31:0] fixed0      = '0;
   logic [31:0] fixed1      = '0;
   int          manual_req  = 0;
   int          manual_seen = 0;
   int          cnt         = -1;
   logic [31:0] cur_a       = '0;
   logic [31:0] cur_b       = '0;

   always @(negedge PCLK) begin
      core_done = 1'b0;
      if (PRESET) begin
         cnt = -1;
      end else if (manual_req != manual_seen) begin
         manual_seen = manual_req;
         core_done   = 1'b1;
         core_res0   = 32'hBAD0_0000;
         core_res1   = 32'hBAD1_0000;
      end else if (cnt > 0) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            core_done = 1'b1;
            core_res0 = fixed_en ? fixed0 : cur_a + 32'h1000;
            core_res1 = fixed_en ? fixed1 : ~cur_b;
            cnt       = -1;
         end
      end
      if (core_start) begin
         start_log.push_back('{core_cmd, core_a, core_b, cyc});
         cur_a = core_a;
         cur_b = core_b;
         cnt   = (done_delay > 0) ? done_delay : -1;
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      rdata = PRDATA;
      err   = PSLVERR;
      @(posedge PCLK);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr_chk(input logic [5:0] addr, input logic [31:0] data,
                         input logic exp_err, input string name);
      logic [31:0] r;
      logic        e;
      apb(1'b1, addr, data, r, e);
      check({name, "_err"}, 32'(e), 32'(exp_err));
   endtask

   task automatic rd_chk(input logic [5:0] addr, input logic [31:0] exp,
                         input logic exp_err, input string name);
      logic [31:0] r;
      logic        e;
      apb(1'b0, addr, 32'h0, r, e);
      check(name, r, exp);
      check({name, "_err"}, 32'(e), 32'(exp_err));
   endtask

   task automatic push_job(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic exp_err, input string name);
      logic [31:0] r;
      logic        e;
      apb(1'b1, A_OPA, a, r, e);
      apb(1'b1, A_OPB, b, r, e);
      apb(1'b1, A_PUSH, {29'd0, cmd}, r, e);
      check({name, "_err"}, 32'(e), 32'(exp_err));
   endtask

   task automatic wait_stat(input logic [31:0] mask, input logic [31:0] value,
                            input int max_reads, input string name);
      logic [31:0] r;
      logic        e;
      r = '0;
      for (int k = 0; k < max_reads; k++) begin
         apb(1'b0, A_STAT, 32'h0, r, e);
         if ((r & mask) == value) break;
      end
      check(name, r & mask, value);
   endtask

   task automatic wait_starts(input int n, input int max_cycles, input string name);
      for (int k = 0; k < max_cycles; k++) begin
         if (start_log.size() >= n) break;
         @(negedge PCLK);
      end
      check(name, 32'(start_log.size()), 32'(n));
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      string       name;
   } vec_t;

   initial begin
      vec_t        vecs[18];
      logic [31:0] r;
      logic        e;
      int          base;
      logic [2:0]  pc[5];
      logic [31:0] pa[5];
      logic [31:0] pb[5];

      vecs[0]  = '{1'b0, A_STAT, 32'h0,         32'h0,         1'b0, "rst_stat"};
      vecs[1]  = '{1'b0, A_CTRL, 32'h0,         32'h0,         1'b0, "rst_ctrl"};
      vecs[2]  = '{1'b0, 6'h3C,  32'h0,         32'h0,         1'b1, "rd_bad_3c"};
      vecs[3]  = '{1'b1, 6'h20,  32'hFFFF_FFFF, 32'h0,         1'b1, "wr_bad_20"};
      vecs[4]  = '{1'b1, A_OPA,  32'h1234_5678, 32'h0,         1'b0, "wr_opa"};
      vecs[5]  = '{1'b0, A_OPA,  32'h0,         32'h1234_5678, 1'b0, "rd_opa"};
      vecs[6]  = '{1'b1, A_OPB,  32'hCAFE_F00D, 32'h0,         1'b0, "wr_opb"};
      vecs[7]  = '{1'b0, A_OPB,  32'h0,         32'hCAFE_F00D, 1'b0, "rd_opb"};
      vecs[8]  = '{1'b1, A_CTRL, 32'h0000_0306, 32'h0,         1'b0, "wr_ctrl"};
      vecs[9]  = '{1'b0, A_CTRL, 32'h0,         32'h0000_0304, 1'b0, "rd_ctrl_flush0"};
      vecs[10] = '{1'b0, A_PUSH, 32'h0,         32'h0,         1'b0, "rd_push"};
      vecs[11] = '{1'b0, 6'h02,  32'h0,         32'h0,         1'b1, "rd_unaligned"};
      vecs[12] = '{1'b0, A_RES0, 32'h0,         32'h0,         1'b1, "rd_res0_empty"};
      vecs[13] = '{1'b0, A_STAT, 32'h0,         32'h0004_0000, 1'b0, "stat_udf"};
      vecs[14] = '{1'b1, A_STAT, 32'h000E_0000, 32'h0,         1'b0, "w1c_all"};
      vecs[15] = '{1'b0, A_STAT, 32'h0,         32'h0,         1'b0, "stat_cleared"};
      vecs[16] = '{1'b1, A_CTRL, 32'h0,         32'h0,         1'b0, "wr_ctrl0"};
      vecs[17] = '{1'b0, A_CTRL, 32'h0,         32'h0,         1'b0, "rd_ctrl0"};

      pc = '{3'd1, 3'd3, 3'd7, 3'd1, 3'd3};
      pa = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444, 32'h0000_5555};
      pb = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004, 32'hE000_0005};

      // ---- reset values
      repeat (3) @(negedge PCLK);
      PRESET = 1'b0;
      #1;
      check("rst_int",        32'(INT),        32'h0);
      check("rst_core_start", 32'(core_start), 32'h0);
      check("rst_core_cmd",   32'(core_cmd),   32'h0);
      check("rst_core_a",     core_a,          32'h0);
      check("rst_core_b",     core_b,          32'h0);
      check("rst_prdata",     PRDATA,          32'h0);
      check("rst_pslverr",    32'(PSLVERR),    32'h0);
      check("rst_pready",     32'(PREADY),     32'h1);

      // ---- register map table
      for (int i = 0; i < 18; i++) begin
         apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e);
         if (!vecs[i].wr) check(vecs[i].name, r, vecs[i].exp_rdata);
         check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
      end

      // ---- single SINCOS job with fixed results, 20-cycle core latency
      fixed_en   = 1'b1;
      fixed0     = 32'h0000_8000;
      fixed1     = 32'h0000_DDB3;
      done_delay = 20;
      base       = start_log.size();
      wr_chk(A_CTRL, 32'h1, 1'b0, "t2_en");
      push_job(3'd1, 32'h10c1_5238, 32'h0, 1'b0, "t2_push");
      wait_stat(32'h0001_FF00, 32'h0000_0100, 40, "t2_res_ready");
      check("t2_starts", 32'(start_log.size() - base), 32'd1);
      check("t2_cmd", 32'(start_log[base].cmd), 32'd1);
      check("t2_a", start_log[base].a, 32'h10c1_5238);
      rd_chk(A_RES0, 32'h0000_8000, 1'b0, "t2_res0");
      rd_chk(A_RES1, 32'h0000_DDB3, 1'b0, "t2_res1");
      rd_chk(A_STAT, 32'h0, 1'b0, "t2_stat_empty");
      fixed_en = 1'b0;

      // ---- overflow with EN=0, then drain JOB_DEPTH jobs in order
      done_delay = 1;
      wr_chk(A_CTRL, 32'h0, 1'b0, "t3_dis");
      base = start_log.size();
      for (int i = 0; i < 5; i++)
         push_job(pc[i], pa[i], pb[i], (i >= JOB_DEPTH), "t3_push");
      rd_chk(A_STAT, 32'h0002_0004, 1'b0, "t3_stat_full_ovf");
      check("t3_no_issue", 32'(start_log.size() - base), 32'd0);
      wr_chk(A_CTRL, 32'h1, 1'b0, "t3_en");
      wait_stat(32'h0001_FF00, 32'h0000_0400, 40, "t3_res_full");
      check("t3_nstarts", 32'(start_log.size() - base), 32'(JOB_DEPTH));
      for (int i = 0; i < JOB_DEPTH; i++) begin
         check("t3_order_cmd", 32'(start_log[base+i].cmd), 32'(pc[i]));
         check("t3_order_a",   start_log[base+i].a, pa[i]);
         check("t3_order_b",   start_log[base+i].b, pb[i]);
         if (i > 0)
            check("t3_spacing", 32'(start_log[base+i].cyc - start_log[base+i-1].cyc), 32'd3);
      end
      rd_chk(A_STAT, 32'h0002_0400, 1'b0, "t3_stat_done");
      for (int i = 0; i < JOB_DEPTH; i++) begin
         rd_chk(A_RES0, pa[i] + 32'h1000, 1'b0, "t3_res0");
         rd_chk(A_RES1, ~pb[i], 1'b0, "t3_res1");
      end
      wr_chk(A_STAT, 32'h0002_0000, 1'b0, "t3_w1c_ovf");
      rd_chk(A_STAT, 32'h0, 1'b0, "t3_stat_clear");

      // ---- threshold interrupt and its one-cycle latency
      done_delay = 2;
      wr_chk(A_CTRL, 32'h0000_0205, 1'b0, "t4_ctrl");
      push_job(3'd3, pa[0], pb[0], 1'b0, "t4_push0");
      push_job(3'd7, pa[1], pb[1], 1'b0, "t4_push1");
      wait_stat(32'h0001_FF00, 32'h0000_0200, 40, "t4_res2");
      @(posedge PCLK); #1;
      check("t4_int_at_thresh", 32'(INT), 32'h1);
      apb(1'b0, A_RES1, 32'h0, r, e);
      check("t4_pop_data", r, ~pb[0]);
      check("t4_int_latency", 32'(INT), 32'h1);
      @(posedge PCLK); #1;
      check("t4_int_below", 32'(INT), 32'h0);
      rd_chk(A_RES1, ~pb[1], 1'b0, "t4_pop2");
      wr_chk(A_CTRL, 32'h0000_0204, 1'b0, "t4_ctrl_dis");
      for (int i = 0; i < 5; i++)
         push_job(pc[i], pa[i], pb[i], (i >= JOB_DEPTH), "t4_push");
      @(posedge PCLK); #1;
      check("t4_int_ovf", 32'(INT), 32'h1);
      wr_chk(A_STAT, 32'h0002_0000, 1'b0, "t4_w1c_ovf");
      rd_chk(A_STAT, 32'h0000_0004, 1'b0, "t4_stat_after_w1c");
      check("t4_int_clear", 32'(INT), 32'h0);
      wr_chk(A_CTRL, 32'h0000_0002, 1'b0, "t4_flush");
      rd_chk(A_STAT, 32'h0, 1'b0, "t4_stat_flushed");

      // ---- core timeout: the next job issues TIMEOUT+3 cycles after the first
      done_delay = 0;
      base = start_log.size();
      wr_chk(A_CTRL, 32'h1, 1'b0, "t5_en");
      push_job(3'd1, pa[2], pb[2], 1'b0, "t5_push0");
      push_job(3'd3, pa[3], pb[3], 1'b0, "t5_push1");
      wait_starts(base + 2, 4 * TIMEOUT + 100, "t5_two_starts");
      check("t5_spacing", 32'(start_log[base+1].cyc - start_log[base].cyc), 32'(TIMEOUT + 3));
      check("t5_second_a", start_log[base+1].a, pa[3]);
      push_job(3'd7, pa[4], pb[4], 1'b0, "t5_push2");
      rd_chk(A_STAT, 32'h0009_0001, 1'b0, "t5_stat_tmo_busy");

      // ---- flush mid-WAIT, then a late done that must be ignored
      wr_chk(A_CTRL, 32'h0000_0002, 1'b0, "t6_flush");
      manual_req++;
      repeat (4) @(negedge PCLK);
      rd_chk(A_STAT, 32'h0008_0000, 1'b0, "t6_stat_flushed");
      check("t6_no_issue", 32'(start_log.size() - base), 32'd2);
      rd_chk(A_RES0, 32'h0, 1'b1, "t6_no_result");
      wr_chk(A_STAT, 32'h000E_0000, 1'b0, "t6_w1c");
      rd_chk(A_STAT, 32'h0, 1'b0, "t6_stat_clear");

      // ---- PRESET while a job is in WAIT with INT asserted
      wr_chk(A_CTRL, 32'h0000_0005, 1'b0, "t7_ctrl");
      rd_chk(A_RES0, 32'h0, 1'b1, "t7_udf");
      base = start_log.size();
      push_job(3'd7, 32'h0BAD_CAFE, 32'h0000_0042, 1'b0, "t7_push");
      wait_starts(base + 1, 100, "t7_started");
      repeat (5) @(negedge PCLK);
      #1;
      check("t7_int_before", 32'(INT), 32'h1);
      rd_chk(A_STAT, 32'h0005_0000, 1'b0, "t7_stat_busy");
      @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
      #1;
      check("t7_int",        32'(INT),        32'h0);
      check("t7_core_start", 32'(core_start), 32'h0);
      check("t7_core_cmd",   32'(core_cmd),   32'h0);
      check("t7_core_a",     core_a,          32'h0);
      check("t7_core_b",     core_b,          32'h0);
      check("t7_prdata",     PRDATA,          32'h0);
      check("t7_pslverr",    32'(PSLVERR),    32'h0);
      rd_chk(A_STAT, 32'h0, 1'b0, "t7_stat");
      rd_chk(A_CTRL, 32'h0, 1'b0, "t7_ctrl_rd");
      repeat (10) @(negedge PCLK);
      check("t7_no_issue", 32'(start_log.size() - base), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
